// File: rtl/morse_receiver_if.sv
// Serial Morse line from the transmitter plus decoded letter/status returned by the receiver.
interface morse_receiver_if;
   logic        FrameStart;
   logic        NewBitIn;
   logic        DotDashIn;
   logic [2:0]  LetterOut;
   logic        LetterValid;
   logic        ErrorOut;
   logic        Busy;
   logic [11:0] PatternOut;

   modport master (
      output FrameStart, NewBitIn, DotDashIn,
      input  LetterOut, LetterValid, ErrorOut, Busy, PatternOut
   );

   modport slave (
      input  FrameStart, NewBitIn, DotDashIn,
      output LetterOut, LetterValid, ErrorOut, Busy, PatternOut
   );
endinterface

// File: rtl/morse_receiver.sv
// Rebuilds a 12-bit dot/dash frame from the transmitter line and decodes it to a letter code A..H.
// The line is sampled one cycle after each FrameStart/NewBitIn event; a stalled line aborts the frame.
module morse_receiver #(
   parameter int CLOCK_FREQUENCY = 500,
   parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
   input  logic            ClockIn,
   input  logic            Reset,
   morse_receiver_if.slave rx
);
   // Counter is sized to hold at least a full bit slot so short timeouts still cover one slot.
   localparam int SLOT_CYCLES = CLOCK_FREQUENCY / 2;
   localparam int TMO_SPAN    = (TIMEOUT_CYCLES > SLOT_CYCLES) ? TIMEOUT_CYCLES : SLOT_CYCLES;
   localparam int TW          = (TMO_SPAN > 1) ? $clog2(TMO_SPAN) : 1;
   localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

   state_t        state, state_nxt;
   logic          pending, pending_nxt;
   logic [3:0]    bit_cnt, bit_cnt_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [11:0]   shift_q, shift_nxt;
   logic [11:0]   pattern_q, pattern_nxt;
   logic [2:0]    letter_q, letter_nxt;
   logic          valid_q, valid_nxt;
   logic          error_q, error_nxt;
   logic          hit;
   logic [2:0]    code;

   always_comb begin
      hit  = 1'b1;
      code = 3'd0;
      case (shift_q)
         12'b101110000000: code = 3'd0;
         12'b111010101000: code = 3'd1;
         12'b111010111010: code = 3'd2;
         12'b111010100000: code = 3'd3;
         12'b100000000000: code = 3'd4;
         12'b101011101000: code = 3'd5;
         12'b111011101000: code = 3'd6;
         12'b101010100000: code = 3'd7;
         default:          hit  = 1'b0;
      endcase
   end

   always_ff @(posedge ClockIn or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         pending   <= 1'b0;
         bit_cnt   <= '0;
         tmo_cnt   <= '0;
         shift_q   <= '0;
         pattern_q <= '0;
         letter_q  <= '0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         bit_cnt   <= bit_cnt_nxt;
         tmo_cnt   <= tmo_cnt_nxt;
         shift_q   <= shift_nxt;
         pattern_q <= pattern_nxt;
         letter_q  <= letter_nxt;
         valid_q   <= valid_nxt;
         error_q   <= error_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      bit_cnt_nxt = bit_cnt;
      tmo_cnt_nxt = tmo_cnt;
      shift_nxt   = shift_q;
      pattern_nxt = pattern_q;
      letter_nxt  = letter_q;
      valid_nxt   = 1'b0;
      error_nxt   = 1'b0;

      // FrameStart restarts capture from any state, silently dropping a partial frame.
      if (rx.FrameStart) begin
         state_nxt   = RECV;
         pending_nxt = 1'b1;
         bit_cnt_nxt = '0;
         tmo_cnt_nxt = '0;
      end else begin
         case (state)
            RECV: begin
               if (pending) begin
                  shift_nxt   = {shift_q[10:0], rx.DotDashIn};
                  bit_cnt_nxt = bit_cnt + 4'd1;
                  tmo_cnt_nxt = '0;
                  pending_nxt = rx.NewBitIn;
                  if (bit_cnt == 4'd11) begin
                     state_nxt   = DECODE;
                     pending_nxt = 1'b0;
                  end
               end else begin
                  if (rx.NewBitIn)
                     pending_nxt = 1'b1;
                  if (tmo_cnt == TMO_LIMIT) begin
                     error_nxt   = 1'b1;
                     state_nxt   = IDLE;
                     pending_nxt = 1'b0;
                     bit_cnt_nxt = '0;
                     tmo_cnt_nxt = '0;
                  end else begin
                     tmo_cnt_nxt = tmo_cnt + 1'b1;
                  end
               end
            end
            DECODE: begin
               state_nxt   = IDLE;
               pattern_nxt = shift_q;
               bit_cnt_nxt = '0;
               if (hit) begin
                  letter_nxt = code;
                  valid_nxt  = 1'b1;
               end else begin
                  error_nxt  = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rx.Busy        = (state != IDLE);
   assign rx.LetterOut   = letter_q;
   assign rx.LetterValid = valid_q;
   assign rx.ErrorOut    = error_q;
   assign rx.PatternOut  = pattern_q;
endmodule
